// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory interface: FSM state encoding,
// memory-mapped I/O register addresses and the default access timeout.
package lc3_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } lc3_state_e;

    // Device register addresses decoded when LC3_MMIO_EN is defined
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // Cycles to wait for mem_ack before giving up on an access
    localparam int TIMEOUT_DEFAULT = 16;

    // True when an address belongs to the device register block
    function automatic logic is_mmio_addr(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// Keyboard and display device registers (KBSR/KBDR/DSR/DDR).
// Only instantiated when LC3_MMIO_EN is defined.
// acc is a one-cycle strobe marking the cycle an MMIO access completes;
// addr/we/wdata are stable while acc is high. rdata is combinational so the
// caller can capture it on the same edge as acc.
module lc3_mmio_regs
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        acc,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    input  logic        disp_ready,
    output logic [15:0] rdata,
    output logic        disp_valid,
    output logic [7:0]  disp_data
);

    logic       kbsr_ready;
    logic [7:0] kbdr;

    // Keyboard capture, KBDR-read acknowledge and display write pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            kbsr_ready <= 1'b0;
            kbdr       <= 8'h00;
            disp_valid <= 1'b0;
            disp_data  <= 8'h00;
        end else begin
            disp_valid <= 1'b0;
            // A new keystroke wins over a simultaneous KBDR read so no
            // character is lost.
            if (kbd_valid) begin
                kbsr_ready <= 1'b1;
                kbdr       <= kbd_data;
            end else if (acc && !we && addr == KBDR_ADDR) begin
                kbsr_ready <= 1'b0;
            end
            if (acc && we && addr == DDR_ADDR) begin
                disp_valid <= 1'b1;
                disp_data  <= wdata;
            end
        end
    end

    // Read mux; DDR and unknown addresses read as zero
    always_comb begin
        rdata = 16'h0000;
        case (addr)
            KBSR_ADDR: rdata = {kbsr_ready, 15'b0};
            KBDR_ADDR: rdata = {8'h00, kbdr};
            DSR_ADDR:  rdata = {disp_ready, 15'b0};
            default:   rdata = 16'h0000;
        endcase
    end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory interface: owns MAR/MDR, sequences the request/ack handshake
// with external memory and offers MDR to the main bus mux.
// Optional macro LC3_MMIO_EN adds internally decoded keyboard/display
// registers at xFE00-xFE06 and their device ports.
//
// Memory handshake: mem_req is held high from the edge that samples MIO_EN
// until the edge that samples mem_ack (or the timeout). mem_addr, mem_we and
// mem_wdata are stable for the whole time mem_req is high. mem_ack is only
// honoured while the sequencer is in REQ; mem_rdata must be valid with it.
// R is a one-cycle completion pulse in the cycle after the completing edge.
module lc3_mem_if
    import lc3_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       main_bus,
    input  logic              LDMAR,
    input  logic              LDMDR,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic              GateMDR,
    output logic [15:0]       mdr_bus_out,
    output logic              mdr_bus_drive,
    output logic              R,
    output logic              mem_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
`ifdef LC3_MMIO_EN
    input  logic              kbd_valid,
    input  logic [7:0]        kbd_data,
    input  logic              disp_ready,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
`endif
    output logic [1:0]        dbg_state
);

    // Counter must hold TIMEOUT-1 even when TIMEOUT is 1
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lc3_state_e        state;
    logic [ADDR_W-1:0] mar;
    logic [15:0]       mdr;
    logic [CNT_W-1:0]  wait_cnt;

    logic [15:0]       next_addr;    // MAR as it will be after this edge
    logic              next_is_mmio; // request about to start targets MMIO
    logic              mmio_sel;     // MMIO access completing this cycle
    logic [15:0]       mmio_rdata;

    assign next_addr = LDMAR ? main_bus : 16'(mar);

`ifdef LC3_MMIO_EN
    assign next_is_mmio = is_mmio_addr(next_addr);
    assign mmio_sel     = (state == REQ) && is_mmio_addr(16'(mar));

    lc3_mmio_regs u_mmio_regs (
        .clk        (clk),
        .rst        (rst),
        .acc        (mmio_sel),
        .we         (mem_we),
        .addr       (16'(mar)),
        .wdata      (mdr[7:0]),
        .kbd_valid  (kbd_valid),
        .kbd_data   (kbd_data),
        .disp_ready (disp_ready),
        .rdata      (mmio_rdata),
        .disp_valid (disp_valid),
        .disp_data  (disp_data)
    );
`else
    // Without device registers every address goes to external memory
    assign next_is_mmio = 1'b0;
    assign mmio_sel     = 1'b0;
    assign mmio_rdata   = next_addr;
`endif

    // Access sequencer with MAR/MDR, registered handshake outputs and error flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= 16'h0000;
            wait_cnt <= '0;
            R        <= 1'b0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            // MAR/MDR are only frozen while an access is outstanding
            if (state != REQ) begin
                if (LDMAR)
                    mar <= main_bus[ADDR_W-1:0];
                if (LDMDR && !MIO_EN)
                    mdr <= main_bus;
            end

            case (state)
                IDLE: begin
                    R <= 1'b0;
                    if (MIO_EN) begin
                        state    <= REQ;
                        mem_we   <= R_W;
                        wait_cnt <= '0;
                        mem_req  <= !next_is_mmio;
                    end
                end

                REQ: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mmio_sel) begin
                        if (!mem_we)
                            mdr <= mmio_rdata;
                        mem_req <= 1'b0;
                        R       <= 1'b1;
                        state   <= DONE;
                    end else if (mem_ack) begin
                        if (!mem_we)
                            mdr <= mem_rdata;
                        mem_req <= 1'b0;
                        R       <= 1'b1;
                        state   <= DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_err <= 1'b1;
                        mem_req <= 1'b0;
                        R       <= 1'b1;
                        state   <= DONE;
                    end
                end

                DONE: begin
                    R       <= 1'b0;
                    mem_req <= 1'b0;
                    state   <= MIO_EN ? HOLD : IDLE;
                end

                HOLD: begin
                    R <= 1'b0;
                    if (!MIO_EN)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr      = mar;
    assign mem_wdata     = mdr;
    assign mdr_bus_out   = mdr;
    assign mdr_bus_drive = GateMDR;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lc3_mem_if.sv
// Directed bench for lc3_mem_if: reads, writes, MAR freeze, MIO_EN hold,
// timeout, reset mid-access and (with LC3_MMIO_EN) device registers.
module tb_lc3_mem_if;
    import lc3_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] main_bus = 16'h0000;
    logic        LDMAR = 1'b0, LDMDR = 1'b0, MIO_EN = 1'b0, R_W = 1'b0, GateMDR = 1'b0;
    logic [15:0] mdr_bus_out;
    logic        mdr_bus_drive, R, mem_err, mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [1:0]  dbg_state;
`ifdef LC3_MMIO_EN
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        disp_ready = 1'b1;
    logic        disp_valid;
    logic [7:0]  disp_data;
`endif

    lc3_mem_if #(.TIMEOUT(16), .ADDR_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .main_bus      (main_bus),
        .LDMAR         (LDMAR),
        .LDMDR         (LDMDR),
        .MIO_EN        (MIO_EN),
        .R_W           (R_W),
        .GateMDR       (GateMDR),
        .mdr_bus_out   (mdr_bus_out),
        .mdr_bus_drive (mdr_bus_drive),
        .R             (R),
        .mem_err       (mem_err),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
`ifdef LC3_MMIO_EN
        .kbd_valid     (kbd_valid),
        .kbd_data      (kbd_data),
        .disp_ready    (disp_ready),
        .disp_valid    (disp_valid),
        .disp_data     (disp_data),
`endif
        .dbg_state     (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    // Count distinct memory transactions (rising edges of mem_req)
    int   req_starts = 0;
    logic req_d = 1'b0;
    always @(posedge clk) begin
        if (mem_req === 1'b1 && req_d !== 1'b1)
            req_starts++;
        req_d = mem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected result and compare it with what the DUT shows
    task automatic sb_pop(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic load_mar(input logic [15:0] a);
        main_bus = a; LDMAR = 1'b1; step(); LDMAR = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] d);
        main_bus = d; LDMDR = 1'b1; step(); LDMDR = 1'b0;
    endtask

    initial begin : main
        int n;
        int starts0;
        logic [15:0] rnd;

        // Reset
        rst = 1'b0;
        step(); step();
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mdr", mdr_bus_out, 16'h0000);
        check("rst_r", {15'b0, R}, 16'h0000);
        check("rst_req", {15'b0, mem_req}, 16'h0000);
        check("rst_we", {15'b0, mem_we}, 16'h0000);
        check("rst_err", {15'b0, mem_err}, 16'h0000);
        check("rst_state", {14'b0, dbg_state}, {14'b0, IDLE});
        rst = 1'b1;

        // Read x3000 with one wait cycle, MAR freeze attempt during REQ
        load_mar(16'h3000);
        MIO_EN = 1'b1; R_W = 1'b0;
        exp_q.push_back(16'h1234);
        step();
        MIO_EN = 1'b0;
        check("rd_req", {15'b0, mem_req}, 16'h0001);
        check("rd_addr", mem_addr, 16'h3000);
        check("rd_we", {15'b0, mem_we}, 16'h0000);
        main_bus = 16'h5555; LDMAR = 1'b1; LDMDR = 1'b1;
        step();
        LDMAR = 1'b0; LDMDR = 1'b0;
        check("freeze_addr", mem_addr, 16'h3000);
        check("freeze_mdr", mdr_bus_out, 16'h0000);
        check("rd_no_early_r", {15'b0, R}, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        check("rd_r_pulse", {15'b0, R}, 16'h0001);
        check("rd_req_drop", {15'b0, mem_req}, 16'h0000);
        sb_pop("rd_mdr", mdr_bus_out);
        GateMDR = 1'b1;
        step();
        check("rd_r_once", {15'b0, R}, 16'h0000);
        check("rd_drive", {15'b0, mdr_bus_drive}, 16'h0001);
        check("rd_bus_out", mdr_bus_out, 16'h1234);
        GateMDR = 1'b0;

        // Zero-wait read: R two edges after MIO_EN is driven
        rnd = 16'($urandom_range(0, 16'hFFFF));
        MIO_EN = 1'b1; R_W = 1'b0;
        exp_q.push_back(rnd);
        step();
        MIO_EN = 1'b0;
        mem_ack = 1'b1; mem_rdata = rnd;
        step();
        mem_ack = 1'b0;
        check("zw_r", {15'b0, R}, 16'h0001);
        sb_pop("zw_mdr", mdr_bus_out);
        step();

        // Write xBEEF to x4000 with MIO_EN held through R and 3 more cycles
        load_mar(16'h4000);
        load_mdr(16'hBEEF);
        starts0 = req_starts;
        MIO_EN = 1'b1; R_W = 1'b1;
        exp_q.push_back(16'hBEEF);
        step();
        check("wr_req", {15'b0, mem_req}, 16'h0001);
        check("wr_we", {15'b0, mem_we}, 16'h0001);
        check("wr_addr", mem_addr, 16'h4000);
        check("wr_wdata", mem_wdata, 16'hBEEF);
        mem_ack = 1'b1; mem_rdata = 16'h0BAD;
        step();
        mem_ack = 1'b0;
        check("wr_r_pulse", {15'b0, R}, 16'h0001);
        sb_pop("wr_data_kept", mem_wdata);
        for (int i = 0; i < 3; i++) step();
        check("hold_state", {14'b0, dbg_state}, {14'b0, HOLD});
        check("hold_no_req", {15'b0, mem_req}, 16'h0000);
        MIO_EN = 1'b0;
        step();
        check("hold_exit", {14'b0, dbg_state}, {14'b0, IDLE});
        check("hold_one_txn", 16'(req_starts - starts0), 16'h0001);

        // Timeout: no ack, MDR must stay xBEEF
        load_mar(16'h6000);
        MIO_EN = 1'b1; R_W = 1'b0;
        exp_q.push_back(16'hBEEF);
        step();
        MIO_EN = 1'b0;
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check("to_req_cycles", 16'(n), 16'd16);
        check("to_r", {15'b0, R}, 16'h0001);
        check("to_err", {15'b0, mem_err}, 16'h0001);
        sb_pop("to_mdr", mdr_bus_out);
        // A stray ack while idle changes nothing
        step();
        mem_ack = 1'b1; mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        check("stray_ack_mdr", mdr_bus_out, 16'hBEEF);
        check("stray_ack_r", {15'b0, R}, 16'h0000);
        for (int i = 0; i < 3; i++) step();
        check("err_sticky", {15'b0, mem_err}, 16'h0001);

        // Reset in the middle of an access
        load_mar(16'h7000);
        MIO_EN = 1'b1; R_W = 1'b0;
        step();
        MIO_EN = 1'b0;
        check("mid_req_up", {15'b0, mem_req}, 16'h0001);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_req", {15'b0, mem_req}, 16'h0000);
        check("mid_rst_addr", mem_addr, 16'h0000);
        check("mid_rst_mdr", mdr_bus_out, 16'h0000);
        check("mid_rst_state", {14'b0, dbg_state}, {14'b0, IDLE});
        check("mid_rst_err", {15'b0, mem_err}, 16'h0000);
        GateMDR = 1'b1;
        #1;
        check("gate_out", mdr_bus_out, 16'h0000);
        check("gate_drive", {15'b0, mdr_bus_drive}, 16'h0001);
        GateMDR = 1'b0;
        #1;
        check("gate_off", {15'b0, mdr_bus_drive}, 16'h0000);
        step();

`ifdef LC3_MMIO_EN
        // Keyboard character then KBDR read
        kbd_valid = 1'b1; kbd_data = 8'h41;
        step();
        kbd_valid = 1'b0;
        starts0 = req_starts;
        load_mar(KBDR_ADDR);
        MIO_EN = 1'b1; R_W = 1'b0;
        exp_q.push_back(16'h0041);
        step();
        MIO_EN = 1'b0;
        check("kbdr_no_req", {15'b0, mem_req}, 16'h0000);
        step();
        check("kbdr_r", {15'b0, R}, 16'h0001);
        sb_pop("kbdr_mdr", mdr_bus_out);
        step();
        // KBSR[15] must now read as cleared
        load_mar(KBSR_ADDR);
        MIO_EN = 1'b1;
        exp_q.push_back(16'h0000);
        step();
        MIO_EN = 1'b0;
        step();
        sb_pop("kbsr_cleared", mdr_bus_out);
        step();
        // DSR reflects disp_ready
        load_mar(DSR_ADDR);
        MIO_EN = 1'b1;
        exp_q.push_back(16'h8000);
        step();
        MIO_EN = 1'b0;
        step();
        sb_pop("dsr", mdr_bus_out);
        step();
        // DDR write pulses disp_valid
        load_mar(DDR_ADDR);
        load_mdr(16'h0058);
        MIO_EN = 1'b1; R_W = 1'b1;
        step();
        MIO_EN = 1'b0;
        check("ddr_no_valid_yet", {15'b0, disp_valid}, 16'h0000);
        step();
        check("ddr_valid", {15'b0, disp_valid}, 16'h0001);
        check("ddr_data", {8'h00, disp_data}, 16'h0058);
        step();
        check("ddr_valid_pulse", {15'b0, disp_valid}, 16'h0000);
        check("mmio_no_mem_txn", 16'(req_starts - starts0), 16'h0000);
`endif

        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
